// File: rtl/butterfly_issue_pkg.sv
// Shared STFT definitions: butterfly issue FSM states, operation encodings
// and the default frame size.
package butterfly_issue_pkg;

    localparam int unsigned DEF_N_PAIRS = 256;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        ISSUE_ADD,
        ISSUE_SUB
    } bf_state_t;

endpackage

// File: rtl/butterfly_issue.sv
// Collects complex sample pairs (A, B) and issues A+B then A-B to the
// complex FP add/sub stage, tracking the pair index within an STFT frame.
module butterfly_issue
    import butterfly_issue_pkg::*;
#(
    parameter int unsigned N_PAIRS = DEF_N_PAIRS,
    parameter int unsigned IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_re,
    input  logic [31:0]      s_im,
    input  logic             s_last,
    output logic             valid_in,
    output logic [31:0]      re_in1,
    output logic [31:0]      im_in1,
    output logic [31:0]      re_in2,
    output logic [31:0]      im_in2,
    output logic             op,
    output logic [IDX_W-1:0] pair_idx,
    output logic             frame_done,
    output logic             err_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIRS - 1);

    bf_state_t   state;
    logic [31:0] a_re;
    logic [31:0] a_im;
    logic        last_pair;

    always_comb begin
        last_pair = (pair_idx == LAST_IDX);
    end

    // re_in2/im_in2 double as the B operand register; re_in1/im_in1 are
    // loaded from A together with B so all four change only at issue time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GET_A;
            s_ready    <= 1'b1;
            valid_in   <= 1'b0;
            op         <= OP_ADD;
            pair_idx   <= '0;
            frame_done <= 1'b0;
            err_last   <= 1'b0;
            a_re       <= '0;
            a_im       <= '0;
            re_in1     <= '0;
            im_in1     <= '0;
            re_in2     <= '0;
            im_in2     <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                GET_A: begin
                    if (s_valid) begin
                        a_re  <= s_re;
                        a_im  <= s_im;
                        state <= GET_B;
                        if (s_last) begin
                            err_last <= 1'b1;
                        end
                    end
                end
                GET_B: begin
                    if (s_valid) begin
                        re_in1   <= a_re;
                        im_in1   <= a_im;
                        re_in2   <= s_re;
                        im_in2   <= s_im;
                        state    <= ISSUE_ADD;
                        s_ready  <= 1'b0;
                        valid_in <= 1'b1;
                        op       <= OP_ADD;
                        if (s_last != last_pair) begin
                            err_last <= 1'b1;
                        end
                    end
                end
                ISSUE_ADD: begin
                    state      <= ISSUE_SUB;
                    op         <= OP_SUB;
                    frame_done <= last_pair;
                end
                ISSUE_SUB: begin
                    state    <= GET_A;
                    s_ready  <= 1'b1;
                    valid_in <= 1'b0;
                    pair_idx <= last_pair ? '0 : pair_idx + IDX_W'(1);
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_butterfly_issue.sv
// Bench for butterfly_issue with a queue-based reference model of accepted
// samples and the issue slots they produce.
module tb_butterfly_issue;

    localparam int unsigned NP = 4;
    localparam int unsigned IW = 2;
    localparam int          VW = 6 + IW + 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_re;
    logic [31:0]   s_im;
    logic          s_last;
    logic          valid_in;
    logic [31:0]   re_in1;
    logic [31:0]   im_in1;
    logic [31:0]   re_in2;
    logic [31:0]   im_in2;
    logic          op;
    logic [IW-1:0] pair_idx;
    logic          frame_done;
    logic          err_last;

    int total = 0;
    int bad   = 0;

    butterfly_issue #(.N_PAIRS(NP), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_last(s_last), .valid_in(valid_in),
        .re_in1(re_in1), .im_in1(im_in1), .re_in2(re_in2), .im_in2(im_in2),
        .op(op), .pair_idx(pair_idx), .frame_done(frame_done), .err_last(err_last)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted B sample schedules two issue slots.
    typedef struct {
        bit          sub;
        int unsigned idx;
        bit          fd;
        logic [31:0] a_re, a_im, b_re, b_im;
    } issue_t;

    issue_t      iq[$];
    logic [31:0] hold[4];
    int unsigned m_pairs;
    bit          m_have_a;
    logic [31:0] ma_re, ma_im;
    bit          m_err;
    int unsigned acc_cnt = 0;

    function automatic void model_reset();
        iq.delete();
        hold     = '{default: '0};
        m_pairs  = 0;
        m_have_a = 1'b0;
        m_err    = 1'b0;
        ma_re    = '0;
        ma_im    = '0;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        if (iq.size() != 0)
            return {1'b0, 1'b1, iq[0].sub, IW'(iq[0].idx), iq[0].fd, m_err,
                    iq[0].a_re, iq[0].a_im, iq[0].b_re, iq[0].b_im};
        return {1'b1, 1'b0, 1'b0, IW'(m_pairs % NP), 1'b0, m_err,
                hold[0], hold[1], hold[2], hold[3]};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        logic op_seen;
        op_seen = (iq.size() != 0) ? op : 1'b0;
        return {s_ready, valid_in, op_seen, pair_idx, frame_done, err_last,
                re_in1, im_in1, re_in2, im_in2};
    endfunction

    function automatic void model_commit(input bit v, input logic [31:0] re,
                                         input logic [31:0] im, input bit last);
        bit          rdy;
        int unsigned idx;
        rdy = (iq.size() == 0);
        if (!rdy) begin
            hold = '{iq[0].a_re, iq[0].a_im, iq[0].b_re, iq[0].b_im};
            void'(iq.pop_front());
        end
        if (v && rdy) begin
            acc_cnt++;
            if (!m_have_a) begin
                ma_re    = re;
                ma_im    = im;
                m_have_a = 1'b1;
                if (last) m_err = 1'b1;
            end else begin
                idx = m_pairs % NP;
                if (last != (idx == NP - 1)) m_err = 1'b1;
                iq.push_back('{sub: 1'b0, idx: idx, fd: 1'b0,
                               a_re: ma_re, a_im: ma_im, b_re: re, b_im: im});
                iq.push_back('{sub: 1'b1, idx: idx, fd: (idx == NP - 1),
                               a_re: ma_re, a_im: ma_im, b_re: re, b_im: im});
                m_pairs++;
                m_have_a = 1'b0;
            end
        end
    endfunction

    function automatic bit correct_last();
        return m_have_a && ((m_pairs % NP) == NP - 1);
    endfunction

    task automatic drive(input bit v, input logic [31:0] re, input logic [31:0] im,
                         input bit last);
        s_valid = v;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        advance();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
        total++; if (valid_in !== 1'b0) begin bad++; $display("FAIL reset_valid_in got=%b want=0", valid_in); end
        total++; if (op !== 1'b0) begin bad++; $display("FAIL reset_op got=%b want=0", op); end
        total++; if (pair_idx !== '0) begin bad++; $display("FAIL reset_pair_idx got=%0d want=0", pair_idx); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (err_last !== 1'b0) begin bad++; $display("FAIL reset_err_last got=%b want=0", err_last); end
        total++;
        if ({re_in1, im_in1, re_in2, im_in2} !== '0) begin
            bad++; $display("FAIL reset_operands got=%h want=0", {re_in1, im_in1, re_in2, im_in2});
        end
        advance();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_pair();
        bit          tv[5]   = '{1, 1, 0, 0, 0};
        logic [31:0] tre[5]  = '{32'h3F800000, 32'h40400000, 0, 0, 0};
        logic [31:0] tim[5]  = '{32'h40000000, 32'h40800000, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(tv[i], tre[i], tim[i], 1'b0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL basic_pair[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            if (i == 2) begin
                total++;
                if ({valid_in, op, re_in1, re_in2} !== {1'b1, 1'b0, 32'h3F800000, 32'h40400000}) begin
                    bad++; $display("FAIL basic_add_slot got=%b/%b want=1/0", valid_in, op);
                end
            end
            model_commit(tv[i], tre[i], tim[i], 1'b0);
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] re, im;
        bit          v;
        int          n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            v  = (i == 0) || (i == 6);
            re = $urandom;
            im = $urandom;
            drive(v, re, im, 1'b0);
            if (i < 7 && valid_in === 1'b1) n_valid++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL stall[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(v, re, im, 1'b0);
            advance();
        end
        total++;
        if (n_valid != 0) begin bad++; $display("FAIL stall_no_issue got=%0d want=0", n_valid); end
    endtask

    task automatic test_ready_gating();
        logic [31:0] re, im;
        bit          last;
        bit          want;
        int          n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            re   = $urandom;
            im   = $urandom;
            last = correct_last();
            drive(1'b1, re, im, last);
            want = ((i % 4) < 2);
            if (s_ready === 1'b1) n_hs++;
            total++;
            if (s_ready !== want) begin
                bad++; $display("FAIL gating_ready[%0d] got=%b want=%b", i, s_ready, want);
            end
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL gating[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(1'b1, re, im, last);
            advance();
        end
        total++;
        if (n_hs != 6) begin bad++; $display("FAIL gating_accepts got=%0d want=6", n_hs); end
    endtask

    task automatic test_frame_wrap();
        logic [31:0] re, im;
        bit          v, last;
        int unsigned start;
        int          n_fd = 0;
        apply_reset();
        start = acc_cnt;
        for (int i = 0; i < 80 && (acc_cnt - start) < 8; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            re   = $urandom;
            im   = $urandom;
            last = ((acc_cnt - start) == 7);
            drive(v, re, im, last);
            if (frame_done === 1'b1) n_fd++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL frame_wrap[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(v, re, im, last);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b0);
            if (frame_done === 1'b1) n_fd++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL frame_tail[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(1'b0, '0, '0, 1'b0);
            advance();
        end
        total++; if (acc_cnt - start != 8) begin bad++; $display("FAIL frame_accepts got=%0d want=8", acc_cnt - start); end
        total++; if (n_fd != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", n_fd); end
        total++; if (pair_idx !== '0) begin bad++; $display("FAIL frame_idx_wrap got=%0d want=0", pair_idx); end
        total++; if (err_last !== 1'b0) begin bad++; $display("FAIL frame_err got=%b want=0", err_last); end
    endtask

    task automatic test_random();
        logic [31:0] re, im;
        bit          v, last;
        for (int i = 0; i < 200; i++) begin
            v    = $urandom_range(0, 1);
            re   = $urandom;
            im   = $urandom;
            last = correct_last();
            drive(v, re, im, last);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(v, re, im, last);
            advance();
        end
    endtask

    task automatic test_misaligned_last();
        logic [31:0] re, im;
        bit          v, last;
        int unsigned start;
        apply_reset();
        start = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            v    = ((acc_cnt - start) < 8) && ($urandom_range(0, 2) != 0);
            re   = $urandom;
            im   = $urandom;
            last = ((acc_cnt - start) == 2);
            drive(v, re, im, last);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL misaligned[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(v, re, im, last);
            advance();
        end
        total++; if (err_last !== 1'b1) begin bad++; $display("FAIL misaligned_sticky got=%b want=1", err_last); end
        total++; if (acc_cnt - start != 8) begin bad++; $display("FAIL misaligned_accepts got=%0d want=8", acc_cnt - start); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] re, im;
        int          n_valid = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            re = $urandom;
            im = $urandom;
            drive(1'b1, re, im, 1'b0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL reset_mid_pre[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(1'b1, re, im, 1'b0);
            advance();
        end
        drive(1'b0, '0, '0, 1'b0);
        total++;
        if ({valid_in, op, pair_idx} !== {1'b1, 1'b0, IW'(2)}) begin
            bad++; $display("FAIL reset_mid_add got=%b/%b/%0d want=1/0/2", valid_in, op, pair_idx);
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0);
            if (valid_in !== 1'b0) n_valid++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL reset_mid_post[%0d] got=%h want=%h", i, dut_vec(), model_vec());
            end
            model_commit(1'b0, '0, '0, 1'b0);
            advance();
        end
        total++;
        if (n_valid != 0) begin bad++; $display("FAIL reset_mid_no_sub got=%0d want=0", n_valid); end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        s_last  = 1'b0;
        model_reset();
        test_reset();
        test_basic_pair();
        test_stall();
        test_ready_gating();
        test_frame_wrap();
        test_random();
        test_misaligned_last();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
